// File: rtl/pool_pkg.sv
// Shared types for the pooling-output serializer: channel/word sizing and the
// queued vector record (frame-start flag plus all channel words).
package pool_pkg;
    localparam int NCH = 16;
    localparam int DW  = 32;
    localparam int CHW = $clog2(NCH);

    typedef logic [DW-1:0] word_t;

    typedef struct packed {
        logic                sof;
        word_t [NCH-1:0]     data;
    } pvec_t;

    typedef enum logic {IDLE, SEND} ser_state_t;
endpackage

// File: rtl/pool_vec_fifo.sv
// Register FIFO of whole pooled vectors. Pure storage: the caller decides when a
// push is allowed, so overflow policy lives outside.
module pool_vec_fifo
    import pool_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  pvec_t                    push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output pvec_t                    head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    pvec_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/pool_ch_serializer.sv
// Buffers parallel pooled vectors and replays them one channel word per cycle
// on a valid/ready stream; vectors arriving with no room are dropped and flagged.
module pool_ch_serializer
    import pool_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            input_valid,
    input  logic            sof,
    input  logic [DW-1:0]   d_in [NCH-1:0],
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [CHW-1:0]  out_ch,
    output logic            out_sof,
    output logic            out_last,
    output logic            overflow
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

    ser_state_t     state, state_nx;
    logic [CHW-1:0] ch, ch_nx;
    logic [CW-1:0]  count;
    pvec_t          head;
    pvec_t          wvec;
    logic           last_ch;
    logic           pop;
    logic           write;

    always_comb begin
        wvec.sof = sof;
        for (int i = 0; i < NCH; i++) wvec.data[i] = d_in[i];
    end

    assign last_ch = (ch == LAST_CH);
    assign pop     = (state == SEND) && out_ready && last_ch;
    // A full FIFO still accepts when its head is leaving on this same edge.
    assign write   = input_valid && ((count < DEPTH_C) || pop);

    pool_vec_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (write),
        .push_data (wvec),
        .pop       (pop),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ch       <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            ch       <= ch_nx;
            if (input_valid && !write) overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        ch_nx     = ch;
        out_valid = 1'b0;
        out_data  = '0;
        out_ch    = '0;
        out_sof   = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                // Including the incoming write gives one-cycle latency to the first word.
                if (count != '0 || write) state_nx = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = head.data[ch];
                out_ch    = ch;
                out_sof   = head.sof && (ch == '0);
                out_last  = last_ch;
                if (out_ready) begin
                    if (last_ch) begin
                        ch_nx = '0;
                        if (count == CW'(1) && !write) state_nx = IDLE;
                    end else begin
                        ch_nx = ch + CHW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pool_ch_serializer.sv
// Directed bench for pool_ch_serializer with a word scoreboard and stall checks.
module tb_pool_ch_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic        input_valid;
    logic        sof;
    logic [31:0] d_in [15:0];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_ch;
    logic        out_sof;
    logic        out_last;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int rx    = 0;
    int gap   = 0;
    logic [63:0] exp_q [$];
    logic        stall_prev = 1'b0;
    logic [63:0] prev_out;

    always #5 clk = ~clk;

    pool_ch_serializer #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .input_valid (input_valid),
        .sof         (sof),
        .d_in        (d_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ch      (out_ch),
        .out_sof     (out_sof),
        .out_last    (out_last),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] cur_out();
        return {26'd0, out_sof, out_last, out_ch, out_data};
    endfunction

    task automatic push_exp(input logic [31:0] base, input logic s);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            logic [3:0]  c;
            w = base + 32'(i);
            c = 4'(i);
            exp_q.push_back({26'd0, s && (i == 0), (i == 15), c, w});
        end
    endtask

    task automatic observe();
        if (stall_prev) chk("stall_hold", cur_out(), prev_out);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("extra_word", cur_out(), 64'd0);
            else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("word", cur_out(), e);
                rx++;
            end
        end else if (!out_valid && exp_q.size() != 0) begin
            gap++;
        end
        stall_prev = out_valid && !out_ready;
        prev_out   = cur_out();
    endtask

    // One cycle: drive, observe before the edge, then record an accepted vector.
    task automatic step(input logic iv, input logic s, input logic [31:0] base,
                        input logic rdy, input logic acc);
        input_valid = iv;
        sof         = s;
        out_ready   = rdy;
        for (int i = 0; i < 16; i++) d_in[i] = base + 32'(i);
        #1;
        observe();
        @(posedge clk);
        #1;
        if (acc) push_exp(base, s);
    endtask

    task automatic drain(input int max_cyc, input logic rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            step(1'b0, 1'b0, 32'd0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("idle_after", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        input_valid = 1'b0;
        sof = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        stall_prev = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        input_valid = 1'b0;
        sof = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) d_in[i] = '0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_outs", cur_out(), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        do_reset();

        // single vector, latency 1
        rx = 0; gap = 0;
        chk("t1_pre_valid", 64'(out_valid), 64'd0);
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_first", cur_out(), {26'd0, 1'b1, 1'b0, 4'd0, 32'h100});
        drain(40, 1'b0);
        chk("t1_rx", 64'(rx), 64'd16);
        chk("t1_gap", 64'(gap), 64'd0);

        // four back-to-back vectors, no gap
        rx = 0; gap = 0;
        for (int v = 0; v < 4; v++) step(1'b1, v == 0, 32'h1000 * 32'(v + 1), 1'b1, 1'b1);
        drain(100, 1'b0);
        chk("t2_rx", 64'(rx), 64'd64);
        chk("t2_gap", 64'(gap), 64'd0);
        chk("t2_ovf", 64'(overflow), 64'd0);

        // six vectors into stalled output: last two dropped
        rx = 0;
        for (int v = 0; v < 6; v++)
            step(1'b1, v == 0, 32'h200 + 32'h100 * 32'(v), 1'b0, v < 4);
        chk("t3_ovf", 64'(overflow), 64'd1);
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("t3_ovf_sticky", 64'(overflow), 64'd1);
        drain(200, 1'b0);
        chk("t3_rx", 64'(rx), 64'd64);
        chk("t3_ovf_end", 64'(overflow), 64'd1);

        // full FIFO, push on the ch15 handshake
        do_reset();
        rx = 0;
        for (int v = 0; v < 4; v++) step(1'b1, 1'b0, 32'hA000 + 32'h100 * 32'(v), 1'b0, 1'b1);
        repeat (15) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t4_ch15", 64'(out_ch), 64'd15);
        step(1'b1, 1'b1, 32'hB000, 1'b1, 1'b1);
        chk("t4_ovf", 64'(overflow), 64'd0);
        drain(200, 1'b0);
        chk("t4_rx", 64'(rx), 64'd80);
        chk("t4_ovf_end", 64'(overflow), 64'd0);

        // random backpressure over three vectors
        rx = 0;
        for (int v = 0; v < 3; v++)
            step(1'b1, 1'b1, 32'hC000 + 32'h100 * 32'(v), 1'($urandom_range(0, 1)), 1'b1);
        drain(2000, 1'b1);
        chk("t5_rx", 64'(rx), 64'd48);

        // reset in the middle of a vector
        for (int v = 0; v < 6; v++)
            step(1'b1, 1'b0, 32'hD000 + 32'h100 * 32'(v), 1'b0, v < 4);
        chk("t6_ovf_set", 64'(overflow), 64'd1);
        repeat (7) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t6_ch7", 64'(out_ch), 64'd7);
        rst = 1'b0;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_ovf", 64'(overflow), 64'd0);
        @(posedge clk);
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        stall_prev = 1'b0;
        repeat (3) step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        chk("t6_empty", 64'(out_valid), 64'd0);
        rx = 0;
        step(1'b1, 1'b1, 32'hE000, 1'b1, 1'b1);
        chk("t6_new_ch0", cur_out(), {26'd0, 1'b1, 1'b0, 4'd0, 32'hE000});
        drain(40, 1'b0);
        chk("t6_rx", 64'(rx), 64'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
